chip_bus_monitor: RTL and testbench

- Receiving end of the sensor chip's shift-register control bus: decodes the 8-bit chip signal bundle driven by the speckle sensor controller, fed back via the *_cpy pins or taken internally.
- Rebuilds the chip-side column and row shift-register contents and decodes the selected pixel.
- On every key write-enable pulse, logs a (row, col, flags) event into a FIFO readable by the debug logic (VIO/ILA).
- Keeps saturating event, error and overflow counters.

---
 rtl/chip_bus_monitor.sv | 141 ++++++++++++++
 tb/tb_chip_bus_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/chip_bus_monitor.sv
// Receive side of the sensor shift-register control bus. Mirrors the column and row
// registers, decodes the selected pixel, and logs each key write into an event FIFO.
module chip_bus_monitor #(
    parameter int COLS       = 24,
    parameter int ROWS       = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int NB_CNT     = 16,
    localparam int NB_CIDX   = $clog2(COLS),
    localparam int NB_RIDX   = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_chip_signals,
    input  logic               i_clr_cnt,
    input  logic               i_evt_ready,
    output logic               o_evt_valid,
    output logic [NB_RIDX-1:0] o_evt_row,
    output logic [NB_CIDX-1:0] o_evt_col,
    output logic [2:0]         o_evt_flags,
    output logic               o_fifo_full,
    output logic [NB_CNT-1:0]  o_key_cnt,
    output logic [NB_CNT-1:0]  o_err_cnt,
    output logic [NB_CNT-1:0]  o_ovf_cnt
);
    localparam int NB_PTR = $clog2(FIFO_DEPTH);
    localparam int B_KEY = 7, B_CCLK = 6, B_CRST = 5, B_CDAT = 4;
    localparam int B_RCLK = 3, B_RRST = 2, B_RENA = 1, B_RDAT = 0;

    typedef struct packed {
        logic [NB_RIDX-1:0] row;
        logic [NB_CIDX-1:0] col;
        logic [2:0]         flags;
    } evt_t;

    logic [7:0]        sync1, sync2;
    logic [2:0]        edge_q;   // {key_wren, col_clk, row_clk} delayed one cycle
    logic              key_rise, col_rise, row_rise;
    logic [COLS-1:0]   col_reg;
    logic [ROWS-1:0]   row_reg;
    logic [NB_CIDX-1:0] col_idx;
    logic [NB_RIDX-1:0] row_idx;
    logic              col_onehot, row_onehot;
    evt_t              evt_in, evt_head;
    evt_t              mem [FIFO_DEPTH];
    logic [NB_PTR-1:0] wr_ptr, rd_ptr;
    logic [NB_PTR:0]   count;
    logic              full, push, pop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= i_chip_signals;
            sync2  <= sync1;
            edge_q <= {sync2[B_KEY], sync2[B_CCLK], sync2[B_RCLK]};
        end
    end

    assign key_rise = sync2[B_KEY]  & ~edge_q[2];
    assign col_rise = sync2[B_CCLK] & ~edge_q[1];
    assign row_rise = sync2[B_RCLK] & ~edge_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            if (sync2[B_CRST])  col_reg <= '0;
            else if (col_rise)  col_reg <= {col_reg[COLS-2:0], sync2[B_CDAT]};
            if (sync2[B_RRST])  row_reg <= '0;
            else if (row_rise)  row_reg <= {row_reg[ROWS-2:0], sync2[B_RDAT]};
        end
    end

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        col_idx = '0;
        for (int i = COLS - 1; i >= 0; i--)
            if (col_reg[i]) col_idx = NB_CIDX'(i);
        row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (row_reg[i]) row_idx = NB_RIDX'(i);
    end

    assign col_onehot = (col_reg != '0) && ((col_reg & (col_reg - 1'b1)) == '0);
    assign row_onehot = (row_reg != '0) && ((row_reg & (row_reg - 1'b1)) == '0);

    assign evt_in = '{row: row_idx, col: col_idx,
                      flags: {sync2[B_RENA], row_onehot, col_onehot}};

    assign full = (count == (NB_PTR + 1)'(FIFO_DEPTH));
    assign pop  = o_evt_valid & i_evt_ready;
    assign push = key_rise & (~full | pop);

    // NOTE: the event memory has no reset; stale entries are masked by the count, and reset only clears pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_evt_valid = (count != '0);
    assign o_fifo_full = full;
    assign evt_head    = o_evt_valid ? mem[rd_ptr] : '0;
    assign o_evt_row   = evt_head.row;
    assign o_evt_col   = evt_head.col;
    assign o_evt_flags = evt_head.flags;

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_clr_cnt) begin
            o_key_cnt <= '0;
            o_err_cnt <= '0;
            o_ovf_cnt <= '0;
        end else if (key_rise) begin
            o_key_cnt <= sat_inc(o_key_cnt);
            if (evt_in.flags != 3'b111) o_err_cnt <= sat_inc(o_err_cnt);
            if (full && !pop)           o_ovf_cnt <= sat_inc(o_ovf_cnt);
        end
    end
endmodule

// File: tb/tb_chip_bus_monitor.sv
// Directed bench for chip_bus_monitor: drives the chip bus slowly enough for the
// synchronizer and checks decoded events, FIFO behaviour and counters.
module tb_chip_bus_monitor;
    localparam logic [7:0] KEY = 8'h80, CCLK = 8'h40, CRST = 8'h20, CDAT = 8'h10;
    localparam logic [7:0] RCLK = 8'h08, RRST = 8'h04, RENA = 8'h02, RDAT = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sig;
    logic        clr_cnt, evt_ready;
    logic        evt_valid, fifo_full;
    logic [4:0]  evt_row, evt_col;
    logic [2:0]  evt_flags;
    logic [15:0] key_cnt, err_cnt, ovf_cnt;

    int checks = 0;
    int failures = 0;

    chip_bus_monitor #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_chip_signals(sig), .i_clr_cnt(clr_cnt),
        .i_evt_ready(evt_ready), .o_evt_valid(evt_valid), .o_evt_row(evt_row),
        .o_evt_col(evt_col), .o_evt_flags(evt_flags), .o_fifo_full(fifo_full),
        .o_key_cnt(key_cnt), .o_err_cnt(err_cnt), .o_ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Hold a bus value for n cycles; three cycles lets any edge pass the synchronizer.
    task automatic apply(input logic [7:0] v, input int n);
        sig = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] base, input logic [7:0] bits);
        apply(base | bits, 3);
        apply(base, 3);
    endtask

    task automatic col_shift(input logic d);
        apply(d ? CDAT : 8'h00, 1);
        pulse(d ? CDAT : 8'h00, CCLK);
        apply(8'h00, 1);
    endtask

    task automatic row_shift(input logic d);
        apply(d ? RDAT : 8'h00, 1);
        pulse(d ? RDAT : 8'h00, RCLK);
        apply(8'h00, 1);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig = 8'h00; clr_cnt = 1'b0; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_full",  fifo_full, 0);
        check("rst_event", {evt_row, evt_col, evt_flags}, 0);
        check("rst_cnts",  {key_cnt, err_cnt}, 0);
        check("rst_ovf",   ovf_cnt, 0);

        // Basic decode: col idx 4, row idx 2, row_ena set
        pulse(8'h00, CRST);
        col_shift(1'b1);
        repeat (4) col_shift(1'b0);
        pulse(8'h00, RRST);
        row_shift(1'b1);
        repeat (2) row_shift(1'b0);
        pulse(RENA, KEY);
        check("basic_valid", evt_valid, 1);
        check("basic_row",   evt_row, 2);
        check("basic_col",   evt_col, 4);
        check("basic_flags", evt_flags, 3'b111);
        check("basic_key",   key_cnt, 1);
        check("basic_err",   err_cnt, 0);
        pop_one();
        check("basic_pop",   evt_valid, 0);

        // Error flags: col bits 2 and 0, row empty, row_ena low
        pulse(8'h00, CRST);
        col_shift(1'b1); col_shift(1'b0); col_shift(1'b1);
        pulse(8'h00, RRST);
        pulse(8'h00, KEY);
        check("err_valid", evt_valid, 1);
        check("err_event", {evt_row, evt_col, evt_flags}, 0);
        check("err_cnt",   err_cnt, 1);
        check("err_key",   key_cnt, 2);
        pop_one();

        // Counter clear, then overflow with depth 4
        clr_cnt = 1'b1; @(negedge clk); clr_cnt = 1'b0;
        check("clr_cnts", {key_cnt, err_cnt}, 0);
        pulse(8'h00, CRST);
        col_shift(1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) col_shift(1'b0);
            pulse(8'h00, KEY);
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_cnt",  ovf_cnt, 2);
        check("ovf_key",  key_cnt, 6);
        check("ovf_err",  err_cnt, 6);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", evt_valid, 1);
            check("drain_col",   evt_col, i);
            check("drain_flags", evt_flags, 3'b001);
            pop_one();
        end
        check("drain_empty", evt_valid, 0);
        check("drain_full",  fifo_full, 0);

        // Simultaneous col_clk and key_wren: capture before the shift
        pulse(8'h00, CRST);
        col_shift(1'b1);
        repeat (3) col_shift(1'b0);
        pulse(8'h00, CCLK | KEY);
        check("sim_col",   evt_col, 3);
        check("sim_flags", evt_flags, 3'b001);
        pulse(8'h00, KEY);
        pop_one();
        check("sim_after_col", evt_col, 4);
        pulse(8'h00, KEY);

        // Two queued events, clear counters, then reset
        clr_cnt = 1'b1; @(negedge clk); clr_cnt = 1'b0;
        check("clr_all",   {key_cnt, err_cnt}, 0);
        check("clr_ovf",   ovf_cnt, 0);
        check("clr_valid", evt_valid, 1);
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_event", {evt_row, evt_col, evt_flags}, 0);
        pulse(RENA, KEY);
        check("post_rst_valid", evt_valid, 1);
        check("post_rst_flags", evt_flags, 3'b100);
        check("post_rst_idx",   {evt_row, evt_col}, 0);
        check("post_rst_key",   key_cnt, 1);
        check("post_rst_err",   err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
